// File: rtl/interp_seq.sv
// Purpose : sequences the interpolation adder's A-operand mux through a 9-step
//           program per pilot triple and emits four saturated combined estimates.
// Latency : accept edge T -> idx0 out_valid after edge T+2; 13 edges per zero-stall triple.
// Backpressure: each estimate parks in HOLD (acc/step frozen, sel=111) until out_ready.
//
// Ports:
//   CLK, RST           clock, synchronous active-low reset
//   in_valid/in_ready  pilot triple handshake; E1/E2/E3 signed IN_WIDTH estimates
//   sel                A-operand select code currently applied (111 when idle/holding)
//   out_data/out_idx/out_last/out_valid/out_ready  estimate output handshake
module interp_seq #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 19,
  parameter int ACC_WIDTH = OUT_WIDTH + 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  E1,
  input  logic [IN_WIDTH-1:0]  E2,
  input  logic [IN_WIDTH-1:0]  E3,
  output logic [2:0]           sel,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [1:0]           out_idx,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int EXT = ACC_WIDTH - IN_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [3:0]           step;
  logic [ACC_WIDTH-1:0] acc, reg_2e, reg_5e, e2_q, e3_q;
  logic [ACC_WIDTH-1:0] e1_x, a_op, sum;
  logic                 clr, emit, cin, ovf;
  logic [2:0]           code;
  logic [1:0]           emit_idx;
  logic [OUT_WIDTH-1:0] sat;

  assign e1_x     = {{EXT{E1[IN_WIDTH-1]}}, E1};
  assign in_ready = (state == IDLE);

  // Micro-program ROM: clear flag, operand code and emit slot per step.
  always_comb begin
    clr      = 1'b0;
    code     = 3'b111;
    emit     = 1'b0;
    emit_idx = 2'd0;
    case (step)
      4'd0: begin clr = 1'b1; code = 3'b001; end
      4'd1: begin code = 3'b110; emit = 1'b1; emit_idx = 2'd0; end
      4'd2: begin clr = 1'b1; code = 3'b110; end
      4'd3: begin code = 3'b000; emit = 1'b1; emit_idx = 2'd1; end
      4'd4: begin clr = 1'b1; code = 3'b101; end
      4'd5: begin code = 3'b100; emit = 1'b1; emit_idx = 2'd2; end
      4'd6: begin clr = 1'b1; code = 3'b101; end
      4'd7: begin code = 3'b010; end
      4'd8: begin code = 3'b011; emit = 1'b1; emit_idx = 2'd3; end
      default: ;
    endcase
  end

  assign sel = (state == RUN) ? code : 3'b111;

  // Inverted operands plus cin=1 form exact two's-complement negation.
  always_comb begin
    a_op = '0;
    cin  = 1'b0;
    case (code)
      3'b000: begin a_op = ~e2_q;        cin = 1'b1; end
      3'b001: begin a_op = ~(e2_q << 1); cin = 1'b1; end
      3'b011: a_op = e2_q;
      3'b010: a_op = reg_2e;
      3'b110: a_op = e3_q << 1;
      3'b100: begin a_op = ~(e3_q << 1); cin = 1'b1; end
      3'b101: a_op = reg_5e;
      default: a_op = '0;
    endcase
  end

  assign sum = (clr ? '0 : acc) + a_op + {{(ACC_WIDTH-1){1'b0}}, cin};

  // Overflow when the bits above the output sign bit are not all copies of it.
  assign ovf = ~((&sum[ACC_WIDTH-1:OUT_WIDTH-1]) | ~(|sum[ACC_WIDTH-1:OUT_WIDTH-1]));
  assign sat = ovf ? (sum[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}})
                   : sum[OUT_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (emit) state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = (step == 4'd8) ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      step      <= 4'd0;
      acc       <= '0;
      reg_2e    <= '0;
      reg_5e    <= '0;
      e2_q      <= '0;
      e3_q      <= '0;
      out_data  <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          e2_q   <= {{EXT{E2[IN_WIDTH-1]}}, E2};
          e3_q   <= {{EXT{E3[IN_WIDTH-1]}}, E3};
          reg_5e <= (e1_x << 2) + e1_x;
          step   <= 4'd0;
        end
        RUN: begin
          acc <= sum;
          if (step == 4'd0) reg_2e <= sum;
          // An emit step keeps its step number through HOLD; advance on handshake.
          if (emit) begin
            out_data  <= sat;
            out_idx   <= emit_idx;
            out_last  <= (emit_idx == 2'd3);
            out_valid <= 1'b1;
          end else begin
            step <= step + 4'd1;
          end
        end
        HOLD: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          step      <= (step == 4'd8) ? 4'd0 : step + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_seq.sv
module tb_interp_seq;
  localparam int IW = 17;
  localparam int OW = 19;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] E1 = '0, E2 = '0, E3 = '0;
  logic [2:0]    sel;
  logic [OW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;

  interp_seq dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .E1(E1), .E2(E2), .E3(E3), .sel(sel), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct { longint d; int i; } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0: out_ready=1, 1: random, 2: 5-cycle stall per output

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint sat19(input longint v);
    if (v > 262143) return 262143;
    if (v < -262144) return -262144;
    return v;
  endfunction

  // Reference: the four combined estimates straight from their formulas.
  function automatic longint model(input longint e1, input longint e2, input longint e3, input int idx);
    case (idx)
      0:       return sat19(2*e3 - 2*e2);
      1:       return sat19(2*e3 - e2);
      2:       return sat19(5*e1 - 2*e3);
      default: return sat19(5*e1 - e2);
    endcase
  endfunction

  function automatic longint rnd17();
    logic [IW-1:0] t;
    case ($urandom_range(0, 5))
      0: return 65535;
      1: return -65536;
      default: begin
        t = IW'($urandom);
        return longint'($signed(t));
      end
    endcase
  endfunction

  task automatic send(input longint e1, input longint e2, input longint e3);
    bit ok;
    exp_t e;
    ok = 1'b0;
    @(posedge CLK); #1;
    E1 = e1[IW-1:0]; E2 = e2[IW-1:0]; E3 = e3[IW-1:0];
    in_valid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      @(posedge CLK);
      for (int k = 0; k < 4; k++) begin
        e.d = model(e1, e2, e3, k);
        e.i = k;
        q.push_back(e);
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (q.size() == 0 && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", q.size(), 0);
  endtask

  // out_ready driver, updated just after each rising edge.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    forever begin
      @(posedge CLK); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid) begin
            if (hold_cnt < 5) begin out_ready = 1'b0; hold_cnt++; end
            else begin out_ready = 1'b1; hold_cnt = 0; end
          end else begin
            out_ready = 1'b0;
            hold_cnt = 0;
          end
        end
      endcase
    end
  end

  // Compare process: every falling edge out of reset.
  initial begin
    bit            prev_stall;
    logic [OW-1:0] prev_d;
    logic [1:0]    prev_i;
    exp_t          e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_i = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (out_valid) begin
          chk("hold_sel", sel, 7);
          chk("busy_in_ready", in_ready, 0);
          if (prev_stall) begin
            chk("stall_data", longint'($signed(out_data)), longint'($signed(prev_d)));
            chk("stall_idx", out_idx, prev_i);
          end
          if (out_ready) begin
            if (q.size() == 0) chk("unexpected_output_idx", out_idx, -1);
            else begin
              e = q.pop_front();
              chk("out_data", longint'($signed(out_data)), e.d);
              chk("out_idx", out_idx, e.i);
              chk("out_last", out_last, (e.i == 3) ? 1 : 0);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_i = out_idx;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with in_valid asserted.
    RST = 1'b0;
    in_valid = 1'b1;
    E1 = 17'd10; E2 = 17'd3; E3 = 17'd7;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel", sel, 7);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("no_accept_in_reset", in_ready, 1);

    // Hand-computed values pinning the model.
    chk("lit_nom0", model(10, 3, 7, 0), 8);
    chk("lit_nom1", model(10, 3, 7, 1), 11);
    chk("lit_nom2", model(10, 3, 7, 2), 36);
    chk("lit_nom3", model(10, 3, 7, 3), 47);
    chk("lit_neg0", model(-4, -5, 2, 0), 14);
    chk("lit_neg1", model(-4, -5, 2, 1), 9);
    chk("lit_neg2", model(-4, -5, 2, 2), -24);
    chk("lit_neg3", model(-4, -5, 2, 3), -15);
    chk("lit_sat0", model(65535, -65536, -65536, 0), 0);
    chk("lit_sat1", model(65535, -65536, -65536, 1), -65536);
    chk("lit_sat2", model(65535, -65536, -65536, 2), 262143);
    chk("lit_sat3", model(65535, -65536, -65536, 3), 262143);

    // Nominal with latency and transaction length.
    mode = 0;
    send(10, 3, 7);
    for (int k = 0; k <= 13; k++) begin
      @(negedge CLK);
      if (k < 2)   chk("lat_early_valid", out_valid, 0);
      if (k == 2)  chk("lat_first_valid", out_valid, 1);
      if (k == 12) chk("span_busy", in_ready, 0);
      if (k == 13) chk("span_idle", in_ready, 1);
    end
    wait_done();
    send(-4, -5, 2);
    wait_done();
    send(65535, -65536, -65536);
    wait_done();

    // Backpressure, with ignored in_valid pulses during the run.
    mode = 2;
    send(10, 3, 7);
    in_valid = 1'b1;
    E1 = 17'd1; E2 = 17'd2; E3 = 17'd3;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_done();
    send(-4, -5, 2);
    wait_done();

    // Reset landing on step 5.
    mode = 0;
    send(10, 3, 7);
    repeat (7) @(posedge CLK);
    #1 RST = 1'b0;
    q.delete();
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_sel", sel, 7);
    @(posedge CLK); #1;
    RST = 1'b1;
    send(-4, -5, 2);
    wait_done();

    // Randomized triples with random out_ready.
    mode = 1;
    for (int t = 0; t < 40; t++) begin
      longint a, b, c;
      a = rnd17(); b = rnd17(); c = rnd17();
      send(a, b, c);
    end
    wait_done();
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interp_seq.md
Name: interp_seq

Overview:
- Sequencer and accumulator that generates the operand-select schedule for the interpolation adder's A-side mux and consumes the adder result.
- Accepts one pilot triple (E1, E2, E3) per transaction over a valid/ready input handshake.
- Runs a fixed 9-step micro-program to form four combined estimates, then emits them in order over a valid/ready output handshake.
- Sits between the pilot LS-estimate stage and the interpolation output buffer in the channel-estimation chain.

Parameters:
- IN_WIDTH, 17, signed width of E1/E2/E3.
- OUT_WIDTH, 19, signed width of emitted estimates and of the A-operand.
- ACC_WIDTH, OUT_WIDTH+2, internal accumulator, reg_5E and reg_2E width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-low reset.
- in_valid  in  1  pilot triple valid.
- in_ready  out  1  block can accept a triple.
- E1, E2, E3  in  IN_WIDTH each  signed pilot estimates.
- sel  out  3  current A-operand select code (debug/observe).
- out_data  out  OUT_WIDTH  signed saturated estimate.
- out_idx  out  2  estimate index, 0..3.
- out_last  out  1  high with idx 3.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset values (RST=0 at a CLK edge):
  - in_ready=1; out_valid=0; out_data=0; out_idx=0; out_last=0; sel=3'b111.
  - Accumulator, step counter, reg_2E and reg_5E all cleared; FSM=IDLE.
  - Reset mid-run aborts the transaction; no partial output is emitted.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch E1..E3, load reg_5E=5·E1 (sign-extended (E1<<2)+E1), go RUN with step=0.
- A-operand by sel code, each sign-extended to ACC_WIDTH:
  - 000 = ~E2
  - 001 = ~(2E2)
  - 011 = E2
  - 010 = reg_2E
  - 110 = 2E3
  - 100 = ~(2E3)
  - 101 = reg_5E
  - 111 = 0, never issued in RUN.
- cin=1 for codes 000, 001 and 100, giving exact two's-complement negation; cin=0 otherwise.
- Each RUN step: sum = (clr ? 0 : acc) + A + cin; acc <= sum.
- Program (step: clr, sel, action):
  - 0: clr, 001, also reg_2E <= sum (= −2E2).
  - 1: 110, emit idx0 (2E3−2E2).
  - 2: clr, 110.
  - 3: 000, emit idx1 (2E3−E2).
  - 4: clr, 101.
  - 5: 100, emit idx2 (5E1−2E3).
  - 6: clr, 101.
  - 7: 010.
  - 8: 011, emit idx3 (5E1−E2).
- Emit step:
  - Saturate sum to OUT_WIDTH: clip to +2^(OUT_WIDTH−1)−1 or −2^(OUT_WIDTH−1).
  - Register the result into out_data; set out_idx; set out_last=(idx==3); out_valid=1 next cycle; FSM→HOLD.
- HOLD:
  - sel=111; acc, step and outputs frozen.
  - On out_valid&out_ready: out_valid=0 same edge; advance to the next step in RUN, or go IDLE after idx3.
  - in_ready=1 the cycle after IDLE is entered.
- Latency and throughput:
  - Accept at edge T → idx0 out_valid high from cycle T+3.
  - Zero-stall transaction spans 13 cycles from accept edge to return to IDLE.
  - in_ready=0 throughout RUN/HOLD; in_valid ignored there.
- out_data holds its last value after handshake until the next emit.

Test Plan:
- Reset: hold RST=0 with in_valid=1 → in_ready=1, out_valid=0, out_data=0, sel=111; no accept while in reset.
- Nominal, out_ready tied 1: E1=10, E2=3, E3=7 → outputs in order 8, 11, 36, 47.
  - out_last only with the 47.
  - First out_valid 3 cycles after accept.
- Negative values: E1=−4, E2=−5, E3=2 → outputs 14, 9, −24, −15.
- Saturation: E1=65535, E2=−65536, E3=−65536 (OUT_WIDTH=19).
  - 5E1−E2=393211 → 262143.
  - 2E3−2E2=0.
  - 5E1−2E3=458747 → 262143.
- Backpressure: out_ready=0 for 5 cycles on each output → out_data/out_idx stable, sel=111 during HOLD, same value sequence; in_valid pulses during run not accepted.
- Mid-run reset: assert RST=0 during step 5 → next cycle IDLE, in_ready=1, out_valid=0; new triple after release produces a correct full sequence.
